// File: rtl/cva5_types.sv
// Shared types for the issue stage: the queued-instruction record and
// the helpers that work out a head entry's pre-issue exception.
package cva5_types;

   // Upper bounds on the configurable widths an entry can carry.
   localparam int IQ_MAX_UNITS  = 16;
   localparam int IQ_MAX_RS     = 3;
   localparam int IQ_MAX_PHYS_W = 8;
   localparam int IQ_MAX_ID_W   = 8;

   localparam logic [31:0] ECALL_INSTR      = 32'h0000_0073;
   localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
   localparam logic [4:0]  ECODE_BREAKPOINT = 5'd3;
   localparam logic [4:0]  ECODE_ILLEGAL    = 5'd2;

   typedef struct packed {
      logic [IQ_MAX_ID_W-1:0]                    id;
      logic [31:0]                               pc;
      logic [31:0]                               instruction;
      logic [IQ_MAX_UNITS-1:0]                   unit_needed;
      logic [IQ_MAX_RS-1:0]                      uses_rs;
      logic [IQ_MAX_RS-1:0][IQ_MAX_PHYS_W-1:0]   phys_rs_addr;
      logic                                      uses_rd;
      logic [IQ_MAX_PHYS_W-1:0]                  phys_rd_addr;
      logic                                      exc;
      logic [4:0]                                ecode;
      logic [31:0]                               tval;
   } issue_queue_entry_t;

   // ECALL's privilege-dependent code arrives from decode on the fetch-code lines.
   function automatic logic [4:0] iq_exc_code(input logic fetch_ok, input logic [4:0] fetch_code,
                                              input logic [31:0] instr);
      if (!fetch_ok || instr == ECALL_INSTR)
         return fetch_code;
      else if (instr == EBREAK_INSTR)
         return ECODE_BREAKPOINT;
      else
         return ECODE_ILLEGAL;
   endfunction

   function automatic logic [31:0] iq_exc_tval(input logic fetch_ok, input logic [31:0] pc,
                                               input logic [31:0] instr);
      if (!fetch_ok || instr == EBREAK_INSTR)
         return pc;
      else if (instr == ECALL_INSTR)
         return 32'd0;
      else
         return instr;
   endfunction

endpackage

// File: rtl/issue_queue_fifo.sv
// Circular entry store for the issue queue: pointers, occupancy count and
// payload memory, exposing the head entry combinationally.
module issue_queue_fifo
   import cva5_types::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_flush,
   input  issue_queue_entry_t i_wr_entry,
   output issue_queue_entry_t o_head,
   output logic [CNT_W-1:0]   o_count,
   output logic               o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   issue_queue_entry_t r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push)
         r_mem[r_wr_ptr] <= i_wr_entry;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue between decode and the execution units: buffers
// decoded instructions, issues the head when operands and unit are ready.
module issue_queue
   import cva5_types::*;
#(
   parameter int DEPTH       = 4,
   parameter int NUM_UNITS   = 8,
   parameter int NUM_RS      = 2,
   parameter int PHYS_ADDR_W = 6,
   parameter int ID_W        = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          decode_valid,
   output logic                          decode_ready,
   input  logic [ID_W-1:0]               decode_id,
   input  logic [31:0]                   decode_pc,
   input  logic [31:0]                   decode_instruction,
   input  logic [NUM_UNITS-1:0]          decode_unit_needed,
   input  logic [NUM_RS-1:0]             decode_uses_rs,
   input  logic [NUM_RS*PHYS_ADDR_W-1:0] decode_phys_rs_addr,
   input  logic                          decode_uses_rd,
   input  logic [PHYS_ADDR_W-1:0]        decode_phys_rd_addr,
   input  logic                          decode_fetch_ok,
   input  logic [4:0]                    decode_fetch_code,
   output logic [NUM_RS*PHYS_ADDR_W-1:0] head_phys_rs_addr,
   input  logic [NUM_RS-1:0]             rs_inuse,
   input  logic [NUM_UNITS-1:0]          unit_ready,
   output logic [NUM_UNITS-1:0]          new_request,
   output logic [ID_W-1:0]               issue_id,
   output logic [31:0]                   issue_pc,
   output logic [PHYS_ADDR_W-1:0]        issue_phys_rd_addr,
   output logic                          issue_uses_rd,
   output logic                          instruction_issued,
   input  logic                          issue_hold,
   input  logic                          fetch_flush,
   output logic                          exception_valid,
   output logic [4:0]                    exception_code,
   output logic [31:0]                   exception_pc,
   output logic [31:0]                   exception_tval,
   output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   issue_queue_entry_t w_new_entry;
   issue_queue_entry_t w_head;
   logic               w_push;
   logic               w_full;
   logic               w_head_valid;
   logic [NUM_RS-1:0]  w_operand_ready;
   logic               w_issue_ok;
   logic               w_exc_raise;
   logic [CNT_W-1:0]   w_count;
   logic               w_unused;

   logic               r_exc_valid;
   logic [4:0]         r_exc_code;
   logic [31:0]        r_exc_pc;
   logic [31:0]        r_exc_tval;

   // Exception classification happens once, at push, so the head path stays short.
   always_comb begin
      w_new_entry                               = '0;
      w_new_entry.id[ID_W-1:0]                  = decode_id;
      w_new_entry.pc                            = decode_pc;
      w_new_entry.instruction                   = decode_instruction;
      w_new_entry.unit_needed[NUM_UNITS-1:0]    = decode_unit_needed;
      w_new_entry.uses_rs[NUM_RS-1:0]           = decode_uses_rs;
      for (int i = 0; i < NUM_RS; i++)
         w_new_entry.phys_rs_addr[i][PHYS_ADDR_W-1:0] = decode_phys_rs_addr[i*PHYS_ADDR_W +: PHYS_ADDR_W];
      w_new_entry.uses_rd                       = decode_uses_rd;
      w_new_entry.phys_rd_addr[PHYS_ADDR_W-1:0] = decode_phys_rd_addr;
      w_new_entry.exc   = ~|decode_unit_needed | ~decode_fetch_ok;
      w_new_entry.ecode = iq_exc_code(decode_fetch_ok, decode_fetch_code, decode_instruction);
      w_new_entry.tval  = iq_exc_tval(decode_fetch_ok, decode_pc, decode_instruction);
   end

   assign decode_ready = ~w_full | instruction_issued;
   assign w_push       = decode_valid & decode_ready & ~fetch_flush;

   issue_queue_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_pop      (instruction_issued),
      .i_flush    (fetch_flush),
      .i_wr_entry (w_new_entry),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_full     (w_full)
   );

   assign occupancy    = w_count;
   assign w_head_valid = (w_count != '0);

   always_comb begin
      head_phys_rs_addr = '0;
      w_operand_ready   = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         head_phys_rs_addr[i*PHYS_ADDR_W +: PHYS_ADDR_W] = w_head.phys_rs_addr[i][PHYS_ADDR_W-1:0];
         w_operand_ready[i] = ~rs_inuse[i] | ~w_head.uses_rs[i];
      end
   end

   assign w_issue_ok = w_head_valid & (&w_operand_ready) & ~issue_hold & ~w_head.exc & ~fetch_flush;
   assign new_request        = {NUM_UNITS{w_issue_ok}} & w_head.unit_needed[NUM_UNITS-1:0] & unit_ready;
   assign instruction_issued = |new_request;

   assign issue_id           = w_head.id[ID_W-1:0];
   assign issue_pc           = w_head.pc;
   assign issue_phys_rd_addr = w_head.phys_rd_addr[PHYS_ADDR_W-1:0];
   assign issue_uses_rd      = w_head.uses_rd;

   // The faulting entry is never popped; it waits at the head for the flush.
   assign w_exc_raise = w_head_valid & w_head.exc & ~issue_hold & ~fetch_flush & ~r_exc_valid;

   always_ff @(posedge clk) begin
      if (rst)
         r_exc_valid <= 1'b0;
      else
         r_exc_valid <= w_exc_raise;
   end

   always_ff @(posedge clk) begin
      if (w_exc_raise) begin
         r_exc_code <= w_head.ecode;
         r_exc_pc   <= w_head.pc;
         r_exc_tval <= w_head.tval;
      end
   end

   assign exception_valid = r_exc_valid;
   assign exception_code  = r_exc_code;
   assign exception_pc    = r_exc_pc;
   assign exception_tval  = r_exc_tval;

   // Fields carried for width-generic storage but not consumed at the head.
   assign w_unused = ^w_head;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: table of per-cycle vectors plus
// hand-written exception, flush and reset sequences.
module tb_issue_queue;

   localparam int DEPTH = 4;
   localparam int NU    = 8;
   localparam int NRS   = 2;
   localparam int PW    = 6;
   localparam int IW    = 3;

   logic              clk;
   logic              rst;
   logic              decode_valid;
   logic              decode_ready;
   logic [IW-1:0]     decode_id;
   logic [31:0]       decode_pc;
   logic [31:0]       decode_instruction;
   logic [NU-1:0]     decode_unit_needed;
   logic [NRS-1:0]    decode_uses_rs;
   logic [NRS*PW-1:0] decode_phys_rs_addr;
   logic              decode_uses_rd;
   logic [PW-1:0]     decode_phys_rd_addr;
   logic              decode_fetch_ok;
   logic [4:0]        decode_fetch_code;
   logic [NRS*PW-1:0] head_phys_rs_addr;
   logic [NRS-1:0]    rs_inuse;
   logic [NU-1:0]     unit_ready;
   logic [NU-1:0]     new_request;
   logic [IW-1:0]     issue_id;
   logic [31:0]       issue_pc;
   logic [PW-1:0]     issue_phys_rd_addr;
   logic              issue_uses_rd;
   logic              instruction_issued;
   logic              issue_hold;
   logic              fetch_flush;
   logic              exception_valid;
   logic [4:0]        exception_code;
   logic [31:0]       exception_pc;
   logic [31:0]       exception_tval;
   logic [2:0]        occupancy;

   issue_queue #(
      .DEPTH(DEPTH), .NUM_UNITS(NU), .NUM_RS(NRS), .PHYS_ADDR_W(PW), .ID_W(IW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .decode_valid        (decode_valid),
      .decode_ready        (decode_ready),
      .decode_id           (decode_id),
      .decode_pc           (decode_pc),
      .decode_instruction  (decode_instruction),
      .decode_unit_needed  (decode_unit_needed),
      .decode_uses_rs      (decode_uses_rs),
      .decode_phys_rs_addr (decode_phys_rs_addr),
      .decode_uses_rd      (decode_uses_rd),
      .decode_phys_rd_addr (decode_phys_rd_addr),
      .decode_fetch_ok     (decode_fetch_ok),
      .decode_fetch_code   (decode_fetch_code),
      .head_phys_rs_addr   (head_phys_rs_addr),
      .rs_inuse            (rs_inuse),
      .unit_ready          (unit_ready),
      .new_request         (new_request),
      .issue_id            (issue_id),
      .issue_pc            (issue_pc),
      .issue_phys_rd_addr  (issue_phys_rd_addr),
      .issue_uses_rd       (issue_uses_rd),
      .instruction_issued  (instruction_issued),
      .issue_hold          (issue_hold),
      .fetch_flush         (fetch_flush),
      .exception_valid     (exception_valid),
      .exception_code      (exception_code),
      .exception_pc        (exception_pc),
      .exception_tval      (exception_tval),
      .occupancy           (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic          dv;
      logic [2:0]    id;
      logic [7:0]    un;
      logic [1:0]    urs;
      logic [1:0]    inuse;
      logic [7:0]    ur;
      logic          hold;
      logic          e_rdy;
      logic [7:0]    e_req;
      logic [2:0]    e_occ;
      logic [2:0]    e_iid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic dv, input logic [2:0] id, input logic [7:0] un,
                               input logic [1:0] urs, input logic [1:0] inuse, input logic [7:0] ur,
                               input logic hold, input logic e_rdy, input logic [7:0] e_req,
                               input logic [2:0] e_occ, input logic [2:0] e_iid);
      vec_t v;
      v.dv = dv; v.id = id; v.un = un; v.urs = urs; v.inuse = inuse; v.ur = ur; v.hold = hold;
      v.e_rdy = e_rdy; v.e_req = e_req; v.e_occ = e_occ; v.e_iid = e_iid;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      decode_valid        = 1'b0;
      decode_id           = '0;
      decode_pc           = 32'd0;
      decode_instruction  = 32'h0000_0013;
      decode_unit_needed  = 8'h01;
      decode_uses_rs      = 2'b00;
      decode_phys_rs_addr = '0;
      decode_uses_rd      = 1'b0;
      decode_phys_rd_addr = '0;
      decode_fetch_ok     = 1'b1;
      decode_fetch_code   = 5'd0;
      rs_inuse            = 2'b00;
      unit_ready          = 8'h00;
      issue_hold          = 1'b0;
      fetch_flush         = 1'b0;
   endtask

   // Sources/destination are tagged with the ID so the head payload can be checked.
   task automatic set_decode(input logic [2:0] id, input logic [7:0] un, input logic [1:0] urs,
                             input logic [31:0] instr, input logic [31:0] pc,
                             input logic fok, input logic [4:0] fcode);
      decode_valid        = 1'b1;
      decode_id           = id;
      decode_pc           = pc;
      decode_instruction  = instr;
      decode_unit_needed  = un;
      decode_uses_rs      = urs;
      decode_phys_rs_addr = {3'b100, id, 3'b010, id};
      decode_uses_rd      = id[0];
      decode_phys_rd_addr = {3'b001, id};
      decode_fetch_ok     = fok;
      decode_fetch_code   = fcode;
   endtask

   task automatic exc_seq(input string nm, input logic [31:0] instr, input logic [7:0] un,
                          input logic fok, input logic [4:0] fcode, input logic [31:0] pc,
                          input logic [4:0] e_code, input logic [31:0] e_tval);
      @(negedge clk); idle(); set_decode(3'd6, un, 2'b00, instr, pc, fok, fcode); #1;
      chk({nm, " occ_before"}, 32'(occupancy), 32'd0);
      @(negedge clk); idle(); unit_ready = 8'hFF; #1;
      chk({nm, " occ_head"}, 32'(occupancy), 32'd1);
      chk({nm, " exv_early"}, 32'(exception_valid), 32'd0);
      chk({nm, " req_head"}, 32'(new_request), 32'd0);
      @(negedge clk); idle(); unit_ready = 8'hFF; #1;
      chk({nm, " exv"}, 32'(exception_valid), 32'd1);
      chk({nm, " code"}, 32'(exception_code), 32'(e_code));
      chk({nm, " tval"}, exception_tval, e_tval);
      chk({nm, " pc"}, exception_pc, pc);
      chk({nm, " req_exc"}, 32'(new_request), 32'd0);
      @(negedge clk); idle(); unit_ready = 8'hFF; fetch_flush = 1'b1; #1;
      chk({nm, " exv_pulse_end"}, 32'(exception_valid), 32'd0);
      chk({nm, " req_flush"}, 32'(new_request), 32'd0);
      @(negedge clk); idle(); #1;
      chk({nm, " occ_after_flush"}, 32'(occupancy), 32'd0);
      chk({nm, " rdy_after_flush"}, 32'(decode_ready), 32'd1);
      chk({nm, " exv_after_flush"}, 32'(exception_valid), 32'd0);
   endtask

   initial begin
      // Fill and drain
      vecs.push_back(mk(1, 0, 8'h01, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      vecs.push_back(mk(1, 1, 8'h02, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 1, 0));
      vecs.push_back(mk(1, 2, 8'h04, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 2, 0));
      vecs.push_back(mk(1, 3, 8'h08, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 3, 0));
      vecs.push_back(mk(1, 4, 8'h10, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 4, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 0, 1, 8'h01, 4, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 0, 1, 8'h02, 3, 1));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 0, 1, 8'h04, 2, 2));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 0, 1, 8'h08, 1, 3));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 0, 1, 8'h00, 0, 0));
      // Full with simultaneous push/pop, pointers wrap
      vecs.push_back(mk(1, 4, 8'h01, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      vecs.push_back(mk(1, 5, 8'h01, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 1, 4));
      vecs.push_back(mk(1, 6, 8'h01, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 2, 4));
      vecs.push_back(mk(1, 7, 8'h01, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 3, 4));
      vecs.push_back(mk(1, 0, 8'h01, 2'b00, 2'b00, 8'h01, 0, 1, 8'h01, 4, 4));
      vecs.push_back(mk(1, 1, 8'h01, 2'b00, 2'b00, 8'h01, 0, 1, 8'h01, 4, 5));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h01, 0, 1, 8'h01, 4, 6));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h01, 0, 1, 8'h01, 3, 7));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h01, 0, 1, 8'h01, 2, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h01, 0, 1, 8'h01, 1, 1));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      // Operand stall, unused operands, hold and busy unit
      vecs.push_back(mk(1, 2, 8'h02, 2'b01, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b01, 8'hFF, 0, 1, 8'h00, 1, 2));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b01, 8'hFF, 0, 1, 8'h00, 1, 2));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b01, 8'hFF, 0, 1, 8'h00, 1, 2));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 0, 1, 8'h02, 1, 2));
      vecs.push_back(mk(1, 3, 8'h04, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b11, 8'hFF, 0, 1, 8'h04, 1, 3));
      vecs.push_back(mk(1, 4, 8'h08, 2'b10, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b01, 8'hFF, 0, 1, 8'h08, 1, 4));
      vecs.push_back(mk(1, 5, 8'h02, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFF, 1, 1, 8'h00, 1, 5));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'hFD, 0, 1, 8'h00, 1, 5));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h02, 0, 1, 8'h02, 1, 5));
      vecs.push_back(mk(0, 0, 8'h00, 2'b00, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0));

      idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset occ", 32'(occupancy), 32'd0);
      chk("reset rdy", 32'(decode_ready), 32'd1);
      chk("reset req", 32'(new_request), 32'd0);
      chk("reset issued", 32'(instruction_issued), 32'd0);
      chk("reset exv", 32'(exception_valid), 32'd0);

      foreach (vecs[k]) begin
         @(negedge clk);
         idle();
         if (vecs[k].dv)
            set_decode(vecs[k].id, vecs[k].un, vecs[k].urs, 32'h0000_0013,
                       {27'd0, vecs[k].id, 2'b00}, 1'b1, 5'd0);
         rs_inuse   = vecs[k].inuse;
         unit_ready = vecs[k].ur;
         issue_hold = vecs[k].hold;
         #1;
         chk($sformatf("v%0d rdy", k), 32'(decode_ready), 32'(vecs[k].e_rdy));
         chk($sformatf("v%0d req", k), 32'(new_request), 32'(vecs[k].e_req));
         chk($sformatf("v%0d issued", k), 32'(instruction_issued), 32'(|vecs[k].e_req));
         chk($sformatf("v%0d occ", k), 32'(occupancy), 32'(vecs[k].e_occ));
         chk($sformatf("v%0d exv", k), 32'(exception_valid), 32'd0);
         if (vecs[k].e_occ != 3'd0) begin
            chk($sformatf("v%0d id", k), 32'(issue_id), 32'(vecs[k].e_iid));
            chk($sformatf("v%0d pc", k), issue_pc, {27'd0, vecs[k].e_iid, 2'b00});
            chk($sformatf("v%0d rd", k), 32'(issue_phys_rd_addr), 32'({3'b001, vecs[k].e_iid}));
            chk($sformatf("v%0d uses_rd", k), 32'(issue_uses_rd), 32'(vecs[k].e_iid[0]));
            chk($sformatf("v%0d rs", k), 32'(head_phys_rs_addr),
                32'({3'b100, vecs[k].e_iid, 3'b010, vecs[k].e_iid}));
         end
      end

      exc_seq("illegal", 32'hFFFF_FFFF, 8'h00, 1'b1, 5'd0, 32'h0000_0100, 5'd2, 32'hFFFF_FFFF);
      exc_seq("ecall", 32'h0000_0073, 8'h00, 1'b1, 5'd11, 32'h0000_0200, 5'd11, 32'h0000_0000);
      exc_seq("ebreak", 32'h0010_0073, 8'h00, 1'b1, 5'd0, 32'h0000_0300, 5'd3, 32'h0000_0300);
      exc_seq("fetchfault", 32'h0000_0073, 8'h01, 1'b0, 5'd1, 32'h0000_0400, 5'd1, 32'h0000_0400);

      // Flush together with a push
      @(negedge clk); idle(); set_decode(3'd1, 8'h01, 2'b00, 32'h13, 32'h4, 1'b1, 5'd0); #1;
      chk("flushpush occ0", 32'(occupancy), 32'd0);
      @(negedge clk); idle(); set_decode(3'd2, 8'h01, 2'b00, 32'h13, 32'h8, 1'b1, 5'd0);
      fetch_flush = 1'b1; unit_ready = 8'hFF; #1;
      chk("flushpush occ1", 32'(occupancy), 32'd1);
      chk("flushpush req", 32'(new_request), 32'd0);
      @(negedge clk); idle(); unit_ready = 8'hFF; #1;
      chk("flushpush occ_after", 32'(occupancy), 32'd0);
      chk("flushpush rdy_after", 32'(decode_ready), 32'd1);
      chk("flushpush req_after", 32'(new_request), 32'd0);

      // Reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); set_decode(3'(i), 8'h01, 2'b00, 32'h13, 32'(i * 4), 1'b1, 5'd0); #1;
      end
      @(negedge clk); idle(); rst = 1'b1; #1;
      chk("midreset occ_before", 32'(occupancy), 32'd3);
      @(negedge clk); idle(); rst = 1'b0; unit_ready = 8'hFF; #1;
      chk("midreset occ", 32'(occupancy), 32'd0);
      chk("midreset exv", 32'(exception_valid), 32'd0);
      chk("midreset rdy", 32'(decode_ready), 32'd1);
      chk("midreset req", 32'(new_request), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
